// File: rtl/cache_mem_responder.sv
// ---------------------------------------------------------------------------
// cache_mem_responder
// Backing-store memory model that answers cache refill reads and write-backs.
// Reads are accepted in IDLE, wait a fixed latency, then return either one
// beat (byte/halfword/word) or four consecutive beats (line, in ascending
// word order). Writes are performed in a single cycle at the accepting edge.
//
// Ports
//   clk_g      : single clock, rising-edge active
//   reset      : asynchronous active-high reset
//   rd_req     : read request valid
//   rd_type    : 000 byte, 001 half, 010 word, 100 line, others act as word
//   rd_addr    : read byte address
//   rd_rdy     : read accepted this cycle when high with rd_req
//   ret_valid  : read return beat valid
//   ret_last   : final beat of the current read
//   ret_data   : return data (0 when ret_valid is low)
//   wr_req     : write request valid
//   wr_type    : write type, same encoding as rd_type
//   wr_addr    : write byte address
//   wr_wstrb   : byte enables for non-line writes
//   wr_data    : line writes use all 128 bits (word 0 in [31:0]), others [31:0]
//   wr_rdy     : write accepted this cycle when high with wr_req
// ---------------------------------------------------------------------------
module cache_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic         clk_g,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_LOAD = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_BURST
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [3:0]    r_latCnt;
  logic [3:0]    w_latCntNext;
  logic [1:0]    r_beat;
  logic [1:0]    w_beatNext;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idxNext;
  logic          r_line;
  logic          w_lineNext;

  logic [31:0]   r_mem [MEM_WORDS];

  logic          w_idle;
  logic          w_rdFire;
  logic          w_wrFire;
  logic          w_rdIsLine;
  logic          w_wrIsLine;
  logic [AW-1:0] w_rdWordIdx;
  logic [AW-1:0] w_wrWordIdx;
  logic [AW-1:0] w_beatIdx;
  logic          w_lastBeat;
  logic          w_unused;

  // Address bits outside the store index only fold into an unused wire so the
  // full 32-bit byte address can stay on the port list.
  assign w_unused = ^{rd_addr[31:AW+2], rd_addr[1:0],
                      wr_addr[31:AW+2], wr_addr[1:0]};

  // Only the line encoding is special; every other type moves a full word.
  assign w_rdIsLine  = (rd_type == 3'b100);
  assign w_wrIsLine  = (wr_type == 3'b100);
  assign w_rdWordIdx = rd_addr[AW+1:2];
  assign w_wrWordIdx = wr_addr[AW+1:2];

  // Handshakes are only offered in IDLE and never while reset is held.
  // A write always wins, leaving a simultaneous read pending.
  assign w_idle   = (r_state == IDLE) && !reset;
  assign wr_rdy   = w_idle;
  assign rd_rdy   = w_idle && !wr_req;
  assign w_wrFire = wr_req && wr_rdy;
  assign w_rdFire = rd_req && rd_rdy;

  // Return path is combinational from state so that the asynchronous reset
  // clears it immediately. Line beats walk the 4-aligned base in order.
  assign w_lastBeat = (r_state == RD_BURST) && (!r_line || (r_beat == 2'd3));
  assign w_beatIdx  = r_line ? {r_idx[AW-1:2], r_beat} : r_idx;
  assign ret_valid  = (r_state == RD_BURST);
  assign ret_last   = w_lastBeat;
  assign ret_data   = ret_valid ? r_mem[w_beatIdx] : 32'h0;

  // State and read-context registers; reset aborts any read in flight.
  always_ff @(posedge clk_g or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_latCnt <= 4'd0;
      r_beat   <= 2'd0;
      r_idx    <= '0;
      r_line   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_latCnt <= w_latCntNext;
      r_beat   <= w_beatNext;
      r_idx    <= w_idxNext;
      r_line   <= w_lineNext;
    end
  end

  // Next-state logic: accept in IDLE, count down the latency in RD_WAIT, then
  // stream beats with no backpressure and fall back to IDLE after the last.
  always_comb begin
    w_stateNext  = r_state;
    w_latCntNext = r_latCnt;
    w_beatNext   = r_beat;
    w_idxNext    = r_idx;
    w_lineNext   = r_line;
    unique case (r_state)
      IDLE: begin
        if (w_rdFire) begin
          w_idxNext    = w_rdWordIdx;
          w_lineNext   = w_rdIsLine;
          w_latCntNext = LAT_LOAD;
          w_beatNext   = 2'd0;
          w_stateNext  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_latCnt == 4'd0) begin
          w_stateNext = RD_BURST;
        end else begin
          w_latCntNext = r_latCnt - 4'd1;
        end
      end
      RD_BURST: begin
        if (w_lastBeat) begin
          w_beatNext  = 2'd0;
          w_stateNext = IDLE;
        end else begin
          w_beatNext = r_beat + 2'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Backing store writes. The store is deliberately not reset so contents
  // survive a reset pulse. Line writes ignore the byte strobes.
  always_ff @(posedge clk_g) begin
    if (w_wrFire) begin
      if (w_wrIsLine) begin
        for (int i = 0; i < 4; i++) begin
          r_mem[{w_wrWordIdx[AW-1:2], 2'(i)}] <= wr_data[32*i +: 32];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wr_wstrb[b]) begin
            r_mem[w_wrWordIdx][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 32-bit words in the backing store (power of two).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning the cycles from read acceptance to the first ret_valid beat (legal range 1..15).
REQ-003 SHALL have port clk_g, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port rd_req, input, 1, read request valid from the cache.
REQ-006 SHALL have port rd_type, input, 3, read type: 000 byte, 001 halfword, 010 word, 100 line (4 words).
REQ-007 SHALL have port rd_addr, input, 32, read byte address.
REQ-008 SHALL have port rd_rdy, output, 1, read request accepted this cycle when high together with rd_req.
REQ-009 SHALL have port ret_valid, output, 1, a read return beat is valid.
REQ-010 SHALL have port ret_last, output, 1, marks the final beat of a read.
REQ-011 SHALL have port ret_data, output, 32, read return data.
REQ-012 SHALL have port wr_req, input, 1, write request valid.
REQ-013 SHALL have port wr_type, input, 3, write type, same encoding as rd_type.
REQ-014 SHALL have port wr_addr, input, 32, write byte address.
REQ-015 SHALL have port wr_wstrb, input, 4, byte enables for non-line writes.
REQ-016 SHALL have port wr_data, input, 128, write data: line writes use all 128 bits, word 0 in [31:0]; other types use [31:0].
REQ-017 SHALL have port wr_rdy, output, 1, write request accepted this cycle when high together with wr_req.

Function
REQ-018 SHALL index the store by word address = addr[31:2] modulo MEM_WORDS; a line base = {addr[31:4],4'b0000} modulo MEM_WORDS.
REQ-019 SHALL implement states IDLE, RD_WAIT, RD_BURST; rd_rdy and wr_rdy SHALL be low outside IDLE.
REQ-020 SHALL drive wr_rdy = (state==IDLE) and rd_rdy = (state==IDLE) && !wr_req: a write wins over a simultaneous read, and the read stays pending.
REQ-021 SHALL perform an accepted write at the accepting edge and remain in IDLE: a line write stores words 0..3 at base+0..3 ignoring wr_wstrb; other types merge wr_data[31:0] into the word under wr_wstrb.
REQ-022 SHALL on read acceptance latch address and type, load the latency counter with RD_LATENCY-1 and enter RD_WAIT.
REQ-023 SHALL decrement the latency counter each cycle in RD_WAIT, entering RD_BURST when it reaches 0, so the first ret_valid appears exactly RD_LATENCY cycles after the accept edge.
REQ-024 SHALL in RD_BURST assert ret_valid on every cycle, with no backpressure: a line read returns 4 consecutive beats (base+0, +1, +2, +3, in order; no critical-word-first), other types return 1 beat containing the full addressed word.
REQ-025 SHALL assert ret_last only on the final beat (beat 3 of a line read, beat 0 otherwise), and return to IDLE on the edge after that beat.
REQ-026 SHALL drive ret_data from the store contents at the time of each beat; ret_data SHALL be 0 whenever ret_valid is low.
REQ-027 SHALL keep the beat counter 2 bits wide and wrap line-base word indices modulo MEM_WORDS (top line wraps to word 0 never occurs within a line since bases are 4-aligned).
REQ-028 SHALL accept a new request in the first IDLE cycle following ret_last (one idle cycle between back-to-back reads).
REQ-029 SHALL treat rd_type/wr_type encodings 011, 101, 110, 111 as word type.

Reset
REQ-030 SHALL on reset assertion asynchronously force state IDLE, counters 0, ret_valid 0, ret_last 0, ret_data 0, and hold rd_rdy and wr_rdy at 0 while reset is high.
REQ-031 SHALL abort any in-flight read on reset mid-burst with no further beats; store contents are not cleared by reset.

Verification
REQ-032 Line write wr_addr=0x0000_0040, wr_data=0x4444_4444_3333_3333_2222_2222_1111_1111, then line read rd_addr=0x0000_0048 -> beats 0x11111111,0x22222222,0x33333333,0x44444444, first beat 2 cycles after accept, ret_last on beat 4 only.
REQ-033 Word write wr_addr=0x0000_0010, wstrb=4'b0101, wr_data[31:0]=0xAABBCCDD over stored 0x00000000 -> word read at 0x10 returns 0x00BB00DD with ret_valid=ret_last=1 single beat.
REQ-034 rd_req and wr_req high in same IDLE cycle -> wr_rdy=1, rd_rdy=0; write completes, read accepted next cycle and returns post-write data.
REQ-035 Reset asserted during beat 2 of a line read -> ret_valid, ret_last, ret_data 0 immediately; after release rd_rdy=1 and previously written data intact.
REQ-036 RD_LATENCY=1, back-to-back word reads -> ret_valid 1 cycle after each accept, rd_rdy low throughout RD_WAIT/RD_BURST, high the cycle after ret_last.
REQ-037 Address wrap: write word at byte 0x0000_1000 with MEM_WORDS=1024 -> read at 0x0000_0000 returns the same data.
